// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: memory responder for the execute stage's load/store port.
// It runs one load or store at a time on a word-wide req/gnt/rvalid bus and
// stalls the pipeline until the access is finished.
//   - Execute side: r_mem_*/w_mem_* requests, data_type_i, w_reg_addr_i in;
//     stall_o, misalign_o, bus_err_o and the load write-back (w_reg_*) out.
//   - Bus side: bus_req_o/bus_we_o/bus_addr_o/bus_wdata_o out;
//     bus_gnt_i/bus_rvalid_i/bus_rdata_i in.
// Sub-word stores use read-modify-write. Loads are lane-extracted and then
// sign- or zero-extended.

// lsu_mem_lane: one byte lane of the store merge. It picks either the new
// store data or the old word read back from memory.
//   sel=1 -> new_lane, sel=0 -> old_lane
module lsu_mem_lane #(
  parameter int VEC_W = 8
) (
  input  logic             sel,
  input  logic [VEC_W-1:0] old_lane,
  input  logic [VEC_W-1:0] new_lane,
  output logic [VEC_W-1:0] merged
);
  assign merged = sel ? new_lane : old_lane;
endmodule

module lsu_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r_mem_enable_i,
  input  logic [31:0] r_mem_addr_i,
  input  logic        w_mem_enable_i,
  input  logic [31:0] w_mem_addr_i,
  input  logic [31:0] w_mem_data_i,
  input  logic [2:0]  data_type_i,
  input  logic [4:0]  w_reg_addr_i,
  output logic        stall_o,
  output logic        w_reg_enable_o,
  output logic [4:0]  w_reg_addr_o,
  output logic [31:0] w_reg_data_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;
  localparam logic [2:0] FAULT   = 3'd5;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  dtype;
    logic [4:0]  rd;
    logic        store;
  } req_t;

  logic [2:0]  state_q;
  logic [7:0]  cnt_q;
  req_t        req_q;
  logic [31:0] wdata_q;   // store data, replaced by the merged word after the read
  logic [31:0] rdata_q;
  logic [4:0]  rd_q;
  logic        err_q;

  // Incoming request decode
  logic        req_vld, new_byte, new_half, new_mis;
  logic [31:0] new_addr;
  assign req_vld  = (r_mem_enable_i | w_mem_enable_i) & (data_type_i != 3'd0);
  assign new_addr = w_mem_enable_i ? w_mem_addr_i : r_mem_addr_i;
  assign new_byte = (data_type_i == 3'd1) | (data_type_i == 3'd4);
  assign new_half = (data_type_i == 3'd2) | (data_type_i == 3'd5);
  // Any type that is not byte or half is handled as a full word.
  assign new_mis  = new_half ? new_addr[0] :
                    new_byte ? 1'b0 : (new_addr[1:0] != 2'b00);

  logic is_byte_q, is_half_q, is_word_q;
  assign is_byte_q = (req_q.dtype == 3'd1) | (req_q.dtype == 3'd4);
  assign is_half_q = (req_q.dtype == 3'd2) | (req_q.dtype == 3'd5);
  assign is_word_q = ~is_byte_q & ~is_half_q;

  // Store merge, one instance per byte lane
  logic [NUM_LANES-1:0]            lane_sel;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_src, lane_old, lane_mrg;
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [1:0] LANE = 2'(g);
    assign lane_sel[g] = is_word_q | (is_half_q & (req_q.addr[1] == LANE[1])) |
                         (is_byte_q & (req_q.addr[1:0] == LANE));
    assign lane_src[g] = is_word_q ? wdata_q[g*VEC_W +: VEC_W] :
                         (is_half_q & LANE[0]) ? wdata_q[15:8] : wdata_q[7:0];
    assign lane_old[g] = bus_rdata_i[g*VEC_W +: VEC_W];
    lsu_mem_lane #(.VEC_W(VEC_W)) u_lane (
      .sel      (lane_sel[g]),
      .old_lane (lane_old[g]),
      .new_lane (lane_src[g]),
      .merged   (lane_mrg[g])
    );
  end

  // Load extract: shift the addressed lane down to bit 0, then extend it.
  logic [4:0]  shamt;
  logic [31:0] rsh, ext;
  assign shamt = is_half_q ? {req_q.addr[1], 4'b0} : {req_q.addr[1:0], 3'b0};
  assign rsh   = bus_rdata_i >> shamt;
  always_comb begin
    ext = bus_rdata_i;
    case (req_q.dtype)
      3'd1:    ext = {{24{rsh[7]}}, rsh[7:0]};
      3'd2:    ext = {{16{rsh[15]}}, rsh[15:0]};
      3'd4:    ext = {24'b0, rsh[7:0]};
      3'd5:    ext = {16'b0, rsh[15:0]};
      default: ext = bus_rdata_i;
    endcase
  end

  logic cnt_last;
  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (req_vld) begin
            req_q   <= '{addr: new_addr, dtype: data_type_i, rd: w_reg_addr_i,
                         store: w_mem_enable_i};
            wdata_q <= w_mem_data_i;
            if (new_mis)                             state_q <= FAULT;
            else if (w_mem_enable_i & ~new_byte & ~new_half) state_q <= WR_REQ;
            else                                     state_q <= RD_REQ;
          end
        end
        RD_REQ, WR_REQ, RD_WAIT: begin
          // A handshake on the limit cycle still completes normally.
          if ((state_q == RD_WAIT) ? bus_rvalid_i : bus_gnt_i) begin
            cnt_q <= '0;
            case (state_q)
              RD_REQ: state_q <= RD_WAIT;
              WR_REQ: state_q <= RESP;
              default: begin
                if (req_q.store) begin
                  wdata_q <= lane_mrg;
                  state_q <= WR_REQ;
                end else begin
                  rdata_q <= ext;
                  rd_q    <= req_q.rd;
                  state_q <= RESP;
                end
              end
            endcase
          end else if (cnt_last) begin
            cnt_q   <= '0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin  // RESP, FAULT: one cycle each
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs. The execute-side combinational stall is gated by reset so that
  // every output reads 0 while rst_n is low.
  assign bus_req_o      = (state_q == RD_REQ) | (state_q == WR_REQ);
  assign bus_we_o       = (state_q == WR_REQ);
  assign bus_addr_o     = {req_q.addr[31:2], 2'b00};
  assign bus_wdata_o    = wdata_q;
  assign misalign_o     = (state_q == FAULT);
  assign bus_err_o      = err_q;
  assign w_reg_enable_o = (state_q == RESP) & ~req_q.store & (req_q.rd != 5'd0);
  assign w_reg_addr_o   = rd_q;
  assign w_reg_data_o   = rdata_q;
  assign stall_o        = rst_n & ((state_q == RD_REQ) | (state_q == RD_WAIT) |
                                   (state_q == WR_REQ) | ((state_q == IDLE) & req_vld));

endmodule
